// File: rtl/fir_filter_mc_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg: shared types and elaboration-time helpers for fir_filter_mc.
//   state_e      : controller state (IDLE / MAC)
//   clog2_min1   : ceil(log2(n)) but never less than 1, for index widths
//   result_width : full-precision accumulator width for a sum of products
// No ports; imported by the filter top and its delay-line sub-module.
// ---------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_e;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  // Product width plus growth for summing num_taps products.
  function automatic int result_width(input int in_w, input int coef_w, input int num_taps);
    return in_w + coef_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_filter_mc_if.sv
// ---------------------------------------------------------------------------
// fir_filter_mc_if: sample-in / result-out bundle for fir_filter_mc.
//   in_valid/in_ready : valid/ready sample handshake
//   in_channel/in_data: channel tag and signed sample
//   out_valid         : one-cycle result strobe
//   out_channel/out_result : tag and signed full-precision result
// master = sample source / result sink, slave = the filter.
// ---------------------------------------------------------------------------
interface fir_filter_mc_if #(
  parameter int INPUT_WIDTH  = 8,
  parameter int CH_W         = 1,
  parameter int RESULT_WIDTH = 18
);

  logic                           in_valid;
  logic                           in_ready;
  logic [CH_W-1:0]                in_channel;
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic                           out_valid;
  logic [CH_W-1:0]                out_channel;
  logic signed [RESULT_WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_channel, in_data,
    input  in_ready, out_valid, out_channel, out_result
  );

  modport slave (
    input  in_valid, in_channel, in_data,
    output in_ready, out_valid, out_channel, out_result
  );

endinterface

// File: rtl/fir_filter_mc_delay_line.sv
// ---------------------------------------------------------------------------
// fir_delay_line: one shift register per channel plus a tap read mux.
//   clk, rst_n   : clock, async active-low reset (clears every entry)
//   shift_en     : one bit per channel; shifts that channel's line
//   shift_data   : new sample entering tap 0 of an enabled line
//   rd_channel   : channel selected for the read mux
//   rd_tap       : tap selected for the read mux
//   rd_data      : selected entry (registered storage, combinational mux)
// ---------------------------------------------------------------------------
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int NUM_OF_TAPS  = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int CH_W         = clog2_min1(NUM_CHANNELS),
  parameter int TAP_W        = clog2_min1(NUM_OF_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CHANNELS-1:0]       shift_en,
  input  logic signed [INPUT_WIDTH-1:0] shift_data,
  input  logic [CH_W-1:0]               rd_channel,
  input  logic [TAP_W-1:0]              rd_tap,
  output logic signed [INPUT_WIDTH-1:0] rd_data
);

  logic signed [INPUT_WIDTH-1:0] line_q [NUM_CHANNELS][NUM_OF_TAPS];
  logic signed [INPUT_WIDTH-1:0] line_d [NUM_CHANNELS][NUM_OF_TAPS];

  // Next-state of every line: enabled channels shift by one tap.
  always_comb begin
    line_d = line_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (shift_en[c]) begin
        for (int k = NUM_OF_TAPS - 1; k > 0; k--) begin
          line_d[c][k] = line_q[c][k-1];
        end
        line_d[c][0] = shift_data;
      end else begin
        line_d[c] = line_q[c];
      end
    end
  end

  // Delay-line storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
          line_q[c][k] <= {INPUT_WIDTH{1'b0}};
        end
      end
    end else begin
      line_q <= line_d;
    end
  end

  // Read indices come from the controller's own registers and are always in range.
  assign rd_data = line_q[rd_channel][rd_tap];

endmodule

// File: rtl/fir_filter_mc.sv
// ---------------------------------------------------------------------------
// fir_filter_mc: multi-channel time-multiplexed serial-MAC FIR filter.
// One multiplier-accumulator walks the taps of the accepted channel, one tap
// per clock; coefficients are shared by all channels and writable in IDLE.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : in_valid/in_ready/in_channel/in_data sample handshake,
//                 out_valid/out_channel/out_result result strobe
//   coef_wr_en, coef_addr, coef_wdata : coefficient write port (IDLE only)
//   busy        : high while a MAC pass is running
// Optional build macro FIR_COEF_RB_EN adds coef_rd_addr / coef_rdata, a
// combinational coefficient readback port (out-of-range address reads 0).
// ---------------------------------------------------------------------------
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int  INPUT_WIDTH  = 8,
  parameter int  COEF_WIDTH   = 8,
  parameter int  NUM_OF_TAPS  = 4,
  parameter int  NUM_CHANNELS = 2,
  localparam int CH_W         = clog2_min1(NUM_CHANNELS),
  localparam int TAP_W        = clog2_min1(NUM_OF_TAPS),
  localparam int RESULT_WIDTH = result_width(INPUT_WIDTH, COEF_WIDTH, NUM_OF_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fir_filter_mc_if.slave               bus,
  input  logic                         coef_wr_en,
  input  logic [TAP_W-1:0]             coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
`ifdef FIR_COEF_RB_EN
  input  logic [TAP_W-1:0]             coef_rd_addr,
  output logic signed [COEF_WIDTH-1:0] coef_rdata,
`endif
  output logic                         busy
);

  localparam int PROD_W = INPUT_WIDTH + COEF_WIDTH;
  localparam logic [TAP_W-1:0] LAST_K = TAP_W'(NUM_OF_TAPS - 1);

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic [TAP_W-1:0]                k_q, k_d;
  logic signed [RESULT_WIDTH-1:0]  acc_q, acc_d;
  logic                            out_valid_q, out_valid_d;
  logic [CH_W-1:0]                 out_channel_q, out_channel_d;
  logic signed [RESULT_WIDTH-1:0]  out_result_q, out_result_d;
  logic signed [COEF_WIDTH-1:0]    coef_q [NUM_OF_TAPS];
  logic signed [COEF_WIDTH-1:0]    coef_d [NUM_OF_TAPS];

  logic                            accept_s;
  logic                            ch_valid_s;
  logic                            addr_ok_s;
  logic [NUM_CHANNELS-1:0]         shift_en_s;
  logic signed [INPUT_WIDTH-1:0]   tap_data_s;
  logic signed [PROD_W-1:0]        prod_s;
  logic signed [RESULT_WIDTH-1:0]  prod_ext_s;

  // Range checks only exist when the index width can name missing entries.
  if (NUM_CHANNELS < (1 << CH_W)) begin : g_ch_chk
    assign ch_valid_s = (bus.in_channel < CH_W'(NUM_CHANNELS));
  end else begin : g_ch_all
    assign ch_valid_s = 1'b1;
  end

  if (NUM_OF_TAPS < (1 << TAP_W)) begin : g_addr_chk
    assign addr_ok_s = (coef_addr < TAP_W'(NUM_OF_TAPS));
  end else begin : g_addr_all
    assign addr_ok_s = 1'b1;
  end

  // The handshake completes in IDLE even for a bad channel; such samples just vanish.
  assign accept_s = bus.in_valid && (state_q == IDLE);

  // One-hot shift enable for the addressed channel's delay line.
  always_comb begin
    shift_en_s = {NUM_CHANNELS{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      shift_en_s[c] = accept_s && ch_valid_s && (bus.in_channel == CH_W'(c));
    end
  end

  fir_delay_line #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .NUM_OF_TAPS  (NUM_OF_TAPS),
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W),
    .TAP_W        (TAP_W)
  ) u_delay_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en_s),
    .shift_data (bus.in_data),
    .rd_channel (ch_q),
    .rd_tap     (k_q),
    .rd_data    (tap_data_s)
  );

  // Operands widened first so the product keeps full signed precision.
  assign prod_s     = PROD_W'(tap_data_s) * PROD_W'(coef_q[k_q]);
  assign prod_ext_s = RESULT_WIDTH'(prod_s);

  // Coefficient file next-state: writes land only while IDLE.
  always_comb begin
    coef_d = coef_q;
    if ((state_q == IDLE) && coef_wr_en && addr_ok_s) begin
      coef_d[coef_addr] = coef_wdata;
    end else begin
      coef_d = coef_q;
    end
  end

  // Controller next-state, accumulator and result capture.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    k_d           = k_q;
    acc_d         = acc_q;
    out_valid_d   = 1'b0;
    out_channel_d = out_channel_q;
    out_result_d  = out_result_q;
    case (state_q)
      IDLE: begin
        if (accept_s && ch_valid_s) begin
          ch_d    = bus.in_channel;
          acc_d   = {RESULT_WIDTH{1'b0}};
          k_d     = {TAP_W{1'b0}};
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext_s;
        if (k_q == LAST_K) begin
          out_result_d  = acc_q + prod_ext_s;
          out_channel_d = ch_q;
          out_valid_d   = 1'b1;
          k_d           = {TAP_W{1'b0}};
          state_d       = IDLE;
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All controller, MAC and coefficient state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= {CH_W{1'b0}};
      k_q           <= {TAP_W{1'b0}};
      acc_q         <= {RESULT_WIDTH{1'b0}};
      out_valid_q   <= 1'b0;
      out_channel_q <= {CH_W{1'b0}};
      out_result_q  <= {RESULT_WIDTH{1'b0}};
      for (int i = 0; i < NUM_OF_TAPS; i++) begin
        coef_q[i] <= {COEF_WIDTH{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_result_q  <= out_result_d;
      coef_q        <= coef_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign busy            = (state_q == MAC);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_result  = out_result_q;

`ifdef FIR_COEF_RB_EN
  logic rd_addr_ok_s;

  if (NUM_OF_TAPS < (1 << TAP_W)) begin : g_rd_chk
    assign rd_addr_ok_s = (coef_rd_addr < TAP_W'(NUM_OF_TAPS));
  end else begin : g_rd_all
    assign rd_addr_ok_s = 1'b1;
  end

  // Combinational readback, zero for addresses past the last tap.
  always_comb begin
    coef_rdata = {COEF_WIDTH{1'b0}};
    if (rd_addr_ok_s) begin
      coef_rdata = coef_q[coef_rd_addr];
    end else begin
      coef_rdata = {COEF_WIDTH{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_fir_filter_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_mc: directed self-checking bench for fir_filter_mc
// (default parameters: 8-bit data/coefs, 4 taps, 2 channels).
// A reference model of the delay lines and coefficients produces the
// expected result at each accept edge; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_fir_filter_mc;

  localparam int NT = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic coef_wr_en;
  logic [1:0] coef_addr;
  logic signed [7:0] coef_wdata;
  logic busy;
`ifdef FIR_COEF_RB_EN
  logic [1:0] coef_rd_addr;
  logic signed [7:0] coef_rdata;
`endif

  fir_filter_mc_if #(.INPUT_WIDTH(8), .CH_W(1), .RESULT_WIDTH(18)) bus ();

  fir_filter_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .coef_wr_en (coef_wr_en),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
`ifdef FIR_COEF_RB_EN
    .coef_rd_addr (coef_rd_addr),
    .coef_rdata   (coef_rdata),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ch;
    int res;
    int acc_idx;
  } exp_t;
  exp_t sb_q[$];

  int m_coef [NT];
  int m_line [NC][NT];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int model_sum(input int ch);
    int s;
    s = 0;
    for (int k = 0; k < NT; k++) s += m_line[ch][k] * m_coef[k];
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      m_coef[k] = 0;
      for (int c = 0; c < NC; c++) m_line[c][k] = 0;
    end
  endtask

  // Offer a sample (optionally with a same-edge coef write); waits out back-pressure.
  task automatic send(input int ch, input int d, input bit we, input int wa, input int wv, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_channel = ch[0:0];
    bus.in_data    = d[7:0];
    coef_wr_en     = we;
    coef_addr      = wa[1:0];
    coef_wdata     = wv[7:0];
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) check("ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    if (we) m_coef[wa] = wv;
    for (int k = NT - 1; k > 0; k--) m_line[ch][k] = m_line[ch][k-1];
    m_line[ch][0] = d;
    e.ch  = ch;
    e.res = model_sum(ch);
    #1;
    e.acc_idx = pcyc;
    sb_q.push_back(e);
    bus.in_valid = 1'b0;
    coef_wr_en   = 1'b0;
  endtask

  task automatic coef_write(input int a, input int v, input bit applied);
    @(negedge clk);
    coef_wr_en = 1'b1;
    coef_addr  = a[1:0];
    coef_wdata = v[7:0];
    @(posedge clk);
    if (applied) m_coef[a] = v;
    #1;
    coef_wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  // Result monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_channel", bus.out_channel, e.ch);
        check("out_result", $signed(bus.out_result), e.res);
        check("latency", pcyc - e.acc_idx, NT);
      end
    end
  end

  initial begin
    int w;
    model_clear();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_channel = 1'b0;
    bus.in_data    = 8'sd0;
    coef_wr_en     = 1'b0;
    coef_addr      = 2'd0;
    coef_wdata     = 8'sd0;
`ifdef FIR_COEF_RB_EN
    coef_rd_addr   = 2'd0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_channel", bus.out_channel, 0);
    check("rst_out_result", $signed(bus.out_result), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);

    // Impulse through coefficients {2,4,6,8}.
    coef_write(0, 2, 1'b1);
    coef_write(1, 4, 1'b1);
    coef_write(2, 6, 1'b1);
    coef_write(3, 8, 1'b1);
    send(0, 1, 1'b0, 0, 0, w);
    for (int i = 0; i < 4; i++) begin
      wait_drain();
      send(0, 0, 1'b0, 0, 0, w);
    end
    wait_drain();

    // Channel isolation: 20 (ch1), 2 (ch0), 40 (ch1).
    send(1, 10, 1'b0, 0, 0, w);
    wait_drain();
    send(0, 1, 1'b0, 0, 0, w);
    wait_drain();
    send(1, 0, 1'b0, 0, 0, w);
    wait_drain();

    // Extremes: all-minimum operands.
    for (int k = 0; k < NT; k++) coef_write(k, -128, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(0, -128, 1'b0, 0, 0, w);
      wait_drain();
    end

    // Back-pressure: second offer held while the first pass runs.
    send(1, 7, 1'b0, 0, 0, w);
    send(1, -3, 1'b0, 0, 0, w);
    check("backpressure_wait", w, NT);
    wait_drain();

    // Coefficient write during MAC is ignored, then applied in IDLE.
    send(0, 0, 1'b0, 0, 0, w);
    check("busy_during_mac", busy, 1);
    coef_write(0, 100, 1'b0);
    wait_drain();
    coef_write(0, 100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 1'b0, 0, 0, w);
      wait_drain();
    end
    send(0, 1, 1'b0, 0, 0, w);
    wait_drain();

    // Coefficient write on the same edge as an accept is used by that pass.
    send(0, 1, 1'b1, 0, -5, w);
    wait_drain();

`ifdef FIR_COEF_RB_EN
    coef_rd_addr = 2'd0;
    #1;
    check("coef_rdata0", coef_rdata, m_coef[0]);
    coef_rd_addr = 2'd3;
    #1;
    check("coef_rdata3", coef_rdata, m_coef[3]);
`endif

    // Reset on MAC edge 2 aborts the pass and clears all storage.
    send(1, 9, 1'b0, 0, 0, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete(sb_q.size() - 1);
    model_clear();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_result", $signed(bus.out_result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_in_ready", bus.in_ready, 1);
    check("postrst_out_valid", bus.out_valid, 0);
    send(0, 1, 1'b0, 0, 0, w);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
